// File: rtl/register_file.sv
// -----------------------------------------------------------------------------
// register_file
//
// Architectural register file: two combinational read ports, one clocked write
// port, and one pending bit per register. The pending bit marks a register
// whose result is still outstanding in the pipeline, so reads can detect a
// hazard.
//
// Parameters
//   WIDTH    : data width of each register
//   ADDR_W   : address width, depth = 2**ADDR_W
//   ZERO_REG : 1 -> register 0 reads as 0 and ignores writes and locks
//   BYPASS   : 1 -> a same-cycle write is forwarded to the read ports
//
// Ports
//   CLK                    : clock, all state updates on the rising edge
//   reset                  : asynchronous active-low reset
//   wr_en/wr_addr/wr_data  : write port; a write clears the pending bit
//   lock_en/lock_addr      : sets the pending bit of lock_addr
//   rs1_addr, rs2_addr     : read addresses
//   rs1_data, rs2_data     : combinational read data
//   rs1_pending/rs2_pending: addressed register has an outstanding write
//   any_pending            : OR of all stored pending bits
//
// Handshake: there is no valid/ready pairing; wr_en and lock_en are
// single-cycle strobes sampled on every rising CLK edge while reset is high.
// -----------------------------------------------------------------------------
module register_file #(
  parameter int WIDTH    = 16,
  parameter int ADDR_W   = 4,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              lock_en,
  input  logic [ADDR_W-1:0] lock_addr,
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic [ADDR_W-1:0] rs2_addr,
  output logic [WIDTH-1:0]  rs1_data,
  output logic [WIDTH-1:0]  rs2_data,
  output logic              rs1_pending,
  output logic              rs2_pending,
  output logic              any_pending
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [WIDTH-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0] pend_q;
  logic [DEPTH-1:0] pend_d;

  // Next-state: the lock is applied after the write so that a write and a
  // lock to the same address leave the pending bit set (the lock names a new
  // producer for that register).
  always_comb begin
    regs_d = regs_q;
    pend_d = pend_q;
    if (wr_en) begin
      regs_d[wr_addr] = wr_data;
      pend_d[wr_addr] = 1'b0;
    end
    if (lock_en) begin
      pend_d[lock_addr] = 1'b1;
    end
    // Register 0 is hardwired: anything aimed at it is discarded.
    if (ZERO_REG != 0) begin
      regs_d[0] = '0;
      pend_d[0] = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
      pend_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= regs_d[i];
      end
      pend_q <= pend_d;
    end
  end

  // Read ports. Forwarding is gated by reset so the outputs show the cleared
  // state while reset is held low, and never applies to a hardwired r0.
  logic rs1_is_zero;
  logic rs2_is_zero;
  logic rs1_fwd;
  logic rs2_fwd;

  always_comb begin
    rs1_is_zero = (ZERO_REG != 0) && (rs1_addr == '0);
    rs2_is_zero = (ZERO_REG != 0) && (rs2_addr == '0);
    rs1_fwd     = (BYPASS != 0) && reset && wr_en && (wr_addr == rs1_addr) && !rs1_is_zero;
    rs2_fwd     = (BYPASS != 0) && reset && wr_en && (wr_addr == rs2_addr) && !rs2_is_zero;

    rs1_data    = regs_q[rs1_addr];
    rs1_pending = pend_q[rs1_addr];
    if (rs1_is_zero) begin
      rs1_data    = '0;
      rs1_pending = 1'b0;
    end else if (rs1_fwd) begin
      rs1_data    = wr_data;
      rs1_pending = 1'b0;
    end

    rs2_data    = regs_q[rs2_addr];
    rs2_pending = pend_q[rs2_addr];
    if (rs2_is_zero) begin
      rs2_data    = '0;
      rs2_pending = 1'b0;
    end else if (rs2_fwd) begin
      rs2_data    = wr_data;
      rs2_pending = 1'b0;
    end
  end

  // Stored bits only; a forwarded write does not hide a pending register here.
  assign any_pending = |pend_q;

endmodule

// File: tb/tb_register_file.sv
`timescale 1ns/1ps
module tb_register_file;

  localparam int W = 16;
  localparam int A = 4;

  // ---------------------------------------------------------------- clock/reset
  logic         CLK;
  logic         reset;
  logic         wr_en;
  logic [A-1:0] wr_addr;
  logic [W-1:0] wr_data;
  logic         lock_en;
  logic [A-1:0] lock_addr;
  logic [A-1:0] rs1_addr;
  logic [A-1:0] rs2_addr;

  logic [W-1:0] rs1_data, rs2_data;
  logic         rs1_pending, rs2_pending, any_pending;

  // Second instance: no bypass, r0 is an ordinary register.
  logic [W-1:0] nb_rs1_data, nb_rs2_data;
  logic         nb_rs1_pending, nb_rs2_pending, nb_any_pending;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  register_file #(.WIDTH(W), .ADDR_W(A), .ZERO_REG(1), .BYPASS(1)) dut (
    .CLK(CLK), .reset(reset),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .lock_en(lock_en), .lock_addr(lock_addr),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .rs1_pending(rs1_pending), .rs2_pending(rs2_pending),
    .any_pending(any_pending)
  );

  register_file #(.WIDTH(W), .ADDR_W(A), .ZERO_REG(0), .BYPASS(0)) dut_nb (
    .CLK(CLK), .reset(reset),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .lock_en(lock_en), .lock_addr(lock_addr),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(nb_rs1_data), .rs2_data(nb_rs2_data),
    .rs1_pending(nb_rs1_pending), .rs2_pending(nb_rs2_pending),
    .any_pending(nb_any_pending)
  );

  // ---------------------------------------------------------------- scoreboard
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp;
  int n_cmp = 0;
  int n_err = 0;

  // ---------------------------------------------------------------- drivers
  task automatic drive(input logic we, input logic [A-1:0] wa, input logic [W-1:0] wd,
                       input logic le, input logic [A-1:0] la,
                       input logic [A-1:0] a1, input logic [A-1:0] a2);
    wr_en = we; wr_addr = wa; wr_data = wd;
    lock_en = le; lock_addr = la;
    rs1_addr = a1; rs2_addr = a2;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic sample();
    @(negedge CLK);
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    reset = 1'b0;
    drive(1'b1, 4'd5, 16'hFFFF, 1'b1, 4'd5, 4'd5, 4'd9);
    exp_q.push_back(16'h0000);
    exp_q.push_back(16'h0000);
    exp_q.push_back(16'h0000);
    sample();
    // bypass suppressed while reset is low
    exp = exp_q.pop_front(); n_cmp++;
    if (rs1_data !== exp) begin n_err++; $display("FAIL reset_bypass_rs1: got %h want %h", rs1_data, exp); end
    exp = exp_q.pop_front(); n_cmp++;
    if (rs2_data !== exp) begin n_err++; $display("FAIL reset_rs2: got %h want %h", rs2_data, exp); end
    exp = exp_q.pop_front(); n_cmp++;
    if (W'(any_pending) !== exp) begin n_err++; $display("FAIL reset_any: got %h want %h", any_pending, exp); end
    // an edge under reset must not write or lock
    tick();
    exp_q.push_back(16'h0000);
    exp_q.push_back(16'h0000);
    sample();
    drive(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 4'd5, 4'd9);
    #1;
    exp = exp_q.pop_front(); n_cmp++;
    if (rs1_data !== exp) begin n_err++; $display("FAIL reset_nowrite: got %h want %h", rs1_data, exp); end
    exp = exp_q.pop_front(); n_cmp++;
    if (W'(rs1_pending) !== exp) begin n_err++; $display("FAIL reset_nolock: got %h want %h", rs1_pending, exp); end
    reset = 1'b1;
  endtask

  task automatic test_write_read();
    tick();
    drive(1'b1, 4'd5, 16'h8888, 1'b0, 4'd0, 4'd5, 4'd6);
    exp_q.push_back(16'h8888);  // bypass instance, same cycle
    exp_q.push_back(16'h0000);  // no-bypass instance, same cycle
    sample();
    exp = exp_q.pop_front(); n_cmp++;
    if (rs1_data !== exp) begin n_err++; $display("FAIL wr_bypass_r5: got %h want %h", rs1_data, exp); end
    exp = exp_q.pop_front(); n_cmp++;
    if (nb_rs1_data !== exp) begin n_err++; $display("FAIL wr_nobypass_r5_early: got %h want %h", nb_rs1_data, exp); end
    tick();
    drive(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 4'd5, 4'd6);
    exp_q.push_back(16'h8888);
    exp_q.push_back(16'h0000);
    exp_q.push_back(16'h8888);
    sample();
    exp = exp_q.pop_front(); n_cmp++;
    if (rs1_data !== exp) begin n_err++; $display("FAIL wr_r5_after: got %h want %h", rs1_data, exp); end
    exp = exp_q.pop_front(); n_cmp++;
    if (rs2_data !== exp) begin n_err++; $display("FAIL wr_r6_untouched: got %h want %h", rs2_data, exp); end
    exp = exp_q.pop_front(); n_cmp++;
    if (nb_rs1_data !== exp) begin n_err++; $display("FAIL wr_nobypass_r5_after: got %h want %h", nb_rs1_data, exp); end
  endtask

  task automatic test_bypass();
    tick();
    drive(1'b0, 4'd0, 16'h0, 1'b1, 4'd3, 4'd3, 4'd3);   // lock r3 first
    tick();
    drive(1'b1, 4'd3, 16'h1234, 1'b0, 4'd0, 4'd3, 4'd3);
    exp_q.push_back(16'h1234);
    exp_q.push_back(16'h1234);
    exp_q.push_back(16'h0000);  // forwarded write hides pending
    exp_q.push_back(16'h0001);  // stored pending still counted
    exp_q.push_back(16'h0001);  // no-bypass sees stored pending
    exp_q.push_back(16'h0000);  // no-bypass sees old data
    sample();
    exp = exp_q.pop_front(); n_cmp++;
    if (rs1_data !== exp) begin n_err++; $display("FAIL byp_rs1: got %h want %h", rs1_data, exp); end
    exp = exp_q.pop_front(); n_cmp++;
    if (rs2_data !== exp) begin n_err++; $display("FAIL byp_rs2: got %h want %h", rs2_data, exp); end
    exp = exp_q.pop_front(); n_cmp++;
    if (W'(rs2_pending) !== exp) begin n_err++; $display("FAIL byp_pending: got %h want %h", rs2_pending, exp); end
    exp = exp_q.pop_front(); n_cmp++;
    if (W'(any_pending) !== exp) begin n_err++; $display("FAIL byp_any: got %h want %h", any_pending, exp); end
    exp = exp_q.pop_front(); n_cmp++;
    if (W'(nb_rs1_pending) !== exp) begin n_err++; $display("FAIL byp_nb_pending: got %h want %h", nb_rs1_pending, exp); end
    exp = exp_q.pop_front(); n_cmp++;
    if (nb_rs2_data !== exp) begin n_err++; $display("FAIL byp_nb_data: got %h want %h", nb_rs2_data, exp); end
    tick();
    drive(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 4'd3, 4'd3);
    exp_q.push_back(16'h0000);
    exp_q.push_back(16'h1234);
    sample();
    exp = exp_q.pop_front(); n_cmp++;
    if (W'(any_pending) !== exp) begin n_err++; $display("FAIL byp_any_after: got %h want %h", any_pending, exp); end
    exp = exp_q.pop_front(); n_cmp++;
    if (nb_rs1_data !== exp) begin n_err++; $display("FAIL byp_nb_after: got %h want %h", nb_rs1_data, exp); end
  endtask

  task automatic test_zero_reg();
    tick();
    drive(1'b1, 4'd0, 16'hBEEF, 1'b1, 4'd0, 4'd0, 4'd0);
    exp_q.push_back(16'h0000);  // no bypass on r0
    sample();
    exp = exp_q.pop_front(); n_cmp++;
    if (rs1_data !== exp) begin n_err++; $display("FAIL zero_nobypass: got %h want %h", rs1_data, exp); end
    tick();
    drive(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 4'd0, 4'd0);
    exp_q.push_back(16'h0000);
    exp_q.push_back(16'h0000);
    exp_q.push_back(16'h0000);
    exp_q.push_back(16'hBEEF);  // r0 is ordinary in the second instance
    exp_q.push_back(16'h0001);  // write + lock same address leaves pending
    sample();
    exp = exp_q.pop_front(); n_cmp++;
    if (rs1_data !== exp) begin n_err++; $display("FAIL zero_data: got %h want %h", rs1_data, exp); end
    exp = exp_q.pop_front(); n_cmp++;
    if (W'(rs1_pending) !== exp) begin n_err++; $display("FAIL zero_pending: got %h want %h", rs1_pending, exp); end
    exp = exp_q.pop_front(); n_cmp++;
    if (W'(any_pending) !== exp) begin n_err++; $display("FAIL zero_any: got %h want %h", any_pending, exp); end
    exp = exp_q.pop_front(); n_cmp++;
    if (nb_rs1_data !== exp) begin n_err++; $display("FAIL zero_nb_data: got %h want %h", nb_rs1_data, exp); end
    exp = exp_q.pop_front(); n_cmp++;
    if (W'(nb_rs1_pending) !== exp) begin n_err++; $display("FAIL zero_nb_pending: got %h want %h", nb_rs1_pending, exp); end
    tick();
    drive(1'b1, 4'd0, 16'h0000, 1'b0, 4'd0, 4'd0, 4'd0);  // clear nb r0
    tick();
    drive(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 4'd0, 4'd0);
  endtask

  task automatic test_scoreboard();
    tick();
    drive(1'b0, 4'd0, 16'h0, 1'b1, 4'd7, 4'd7, 4'd7);
    tick();
    drive(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 4'd7, 4'd7);
    exp_q.push_back(16'h0001);
    exp_q.push_back(16'h0001);
    sample();
    exp = exp_q.pop_front(); n_cmp++;
    if (W'(rs1_pending) !== exp) begin n_err++; $display("FAIL sb_lock_pending: got %h want %h", rs1_pending, exp); end
    exp = exp_q.pop_front(); n_cmp++;
    if (W'(any_pending) !== exp) begin n_err++; $display("FAIL sb_lock_any: got %h want %h", any_pending, exp); end
    tick();
    drive(1'b1, 4'd7, 16'h00A5, 1'b1, 4'd7, 4'd7, 4'd7);
    exp_q.push_back(16'h0000);  // lock only affects later cycles
    sample();
    exp = exp_q.pop_front(); n_cmp++;
    if (W'(rs1_pending) !== exp) begin n_err++; $display("FAIL sb_wl_same_cycle: got %h want %h", rs1_pending, exp); end
    tick();
    drive(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 4'd7, 4'd7);
    exp_q.push_back(16'h00A5);
    exp_q.push_back(16'h0001);
    sample();
    exp = exp_q.pop_front(); n_cmp++;
    if (rs1_data !== exp) begin n_err++; $display("FAIL sb_wl_data: got %h want %h", rs1_data, exp); end
    exp = exp_q.pop_front(); n_cmp++;
    if (W'(rs2_pending) !== exp) begin n_err++; $display("FAIL sb_wl_pending: got %h want %h", rs2_pending, exp); end
    tick();
    drive(1'b1, 4'd7, 16'h0011, 1'b0, 4'd0, 4'd7, 4'd7);
    tick();
    drive(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 4'd7, 4'd8);
    exp_q.push_back(16'h0000);
    exp_q.push_back(16'h0000);
    exp_q.push_back(16'h0011);
    sample();
    exp = exp_q.pop_front(); n_cmp++;
    if (W'(rs1_pending) !== exp) begin n_err++; $display("FAIL sb_clear_pending: got %h want %h", rs1_pending, exp); end
    exp = exp_q.pop_front(); n_cmp++;
    if (W'(any_pending) !== exp) begin n_err++; $display("FAIL sb_clear_any: got %h want %h", any_pending, exp); end
    exp = exp_q.pop_front(); n_cmp++;
    if (rs1_data !== exp) begin n_err++; $display("FAIL sb_clear_data: got %h want %h", rs1_data, exp); end
    // write and lock to different addresses
    tick();
    drive(1'b1, 4'd8, 16'h5A5A, 1'b1, 4'd9, 4'd8, 4'd9);
    tick();
    drive(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 4'd8, 4'd9);
    exp_q.push_back(16'h5A5A);
    exp_q.push_back(16'h0000);
    exp_q.push_back(16'h0001);
    sample();
    exp = exp_q.pop_front(); n_cmp++;
    if (rs1_data !== exp) begin n_err++; $display("FAIL sb_diff_data: got %h want %h", rs1_data, exp); end
    exp = exp_q.pop_front(); n_cmp++;
    if (W'(rs1_pending) !== exp) begin n_err++; $display("FAIL sb_diff_wr_pending: got %h want %h", rs1_pending, exp); end
    exp = exp_q.pop_front(); n_cmp++;
    if (W'(rs2_pending) !== exp) begin n_err++; $display("FAIL sb_diff_lock_pending: got %h want %h", rs2_pending, exp); end
  endtask

  task automatic test_reset_clear();
    for (int i = 0; i < 16; i++) begin
      tick();
      drive(1'b1, A'(i), 16'hFFFF, 1'b1, 4'd4, 4'd0, 4'd0);
    end
    tick();   // last write/lock lands; keep strobes active into the reset
    reset = 1'b0;
    exp_q.push_back(16'h0000);
    #0.5;
    exp = exp_q.pop_front(); n_cmp++;
    if (W'(any_pending) !== exp) begin n_err++; $display("FAIL rstclr_any: got %h want %h", any_pending, exp); end
    for (int i = 0; i < 8; i++) begin
      rs1_addr = A'(i);
      rs2_addr = A'(i + 8);
      exp_q.push_back(16'h0000);
      exp_q.push_back(16'h0000);
      exp_q.push_back(16'h0000);
      #0.5;
      exp = exp_q.pop_front(); n_cmp++;
      if (rs1_data !== exp) begin n_err++; $display("FAIL rstclr_rs1 r%0d: got %h want %h", i, rs1_data, exp); end
      exp = exp_q.pop_front(); n_cmp++;
      if (rs2_data !== exp) begin n_err++; $display("FAIL rstclr_rs2 r%0d: got %h want %h", i + 8, rs2_data, exp); end
      exp = exp_q.pop_front(); n_cmp++;
      if (nb_rs1_data !== exp) begin n_err++; $display("FAIL rstclr_nb_rs1 r%0d: got %h want %h", i, nb_rs1_data, exp); end
    end
    tick();
    drive(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 4'd0, 4'd0);
    reset = 1'b1;
  endtask

  task automatic test_reset_during_lock();
    tick();
    drive(1'b1, 4'd5, 16'h1111, 1'b0, 4'd0, 4'd2, 4'd5);
    tick();
    drive(1'b0, 4'd0, 16'h0, 1'b1, 4'd2, 4'd2, 4'd5);
    #1 reset = 1'b0;
    tick();
    lock_en = 1'b0;
    #1 reset = 1'b1;
    exp_q.push_back(16'h0000);
    exp_q.push_back(16'h0000);
    exp_q.push_back(16'h0000);
    sample();
    exp = exp_q.pop_front(); n_cmp++;
    if (W'(rs1_pending) !== exp) begin n_err++; $display("FAIL rstlock_pending: got %h want %h", rs1_pending, exp); end
    exp = exp_q.pop_front(); n_cmp++;
    if (W'(any_pending) !== exp) begin n_err++; $display("FAIL rstlock_any: got %h want %h", any_pending, exp); end
    exp = exp_q.pop_front(); n_cmp++;
    if (rs2_data !== exp) begin n_err++; $display("FAIL rstlock_r5_cleared: got %h want %h", rs2_data, exp); end
  endtask

  // Random traffic against a reference model of the bypass/zero-reg instance.
  task automatic test_random();
    logic [W-1:0] mdl_data [16];
    logic [15:0]  mdl_pend;
    logic         we, le;
    logic [A-1:0] wa, la, a1, a2;
    logic [W-1:0] wd;
    for (int i = 0; i < 16; i++) mdl_data[i] = '0;
    mdl_pend = '0;
    for (int n = 0; n < 300; n++) begin
      tick();
      we = ($urandom_range(0, 1) == 1);
      le = ($urandom_range(0, 3) == 0);
      wa = A'($urandom_range(0, 15));
      la = A'($urandom_range(0, 15));
      a1 = A'($urandom_range(0, 15));
      a2 = ($urandom_range(0, 2) == 0) ? wa : A'($urandom_range(0, 15));
      wd = W'($urandom_range(0, 65535));
      drive(we, wa, wd, le, la, a1, a2);
      exp_q.push_back((a1 == 0) ? 16'h0 : (we && wa == a1) ? wd : mdl_data[a1]);
      exp_q.push_back((a2 == 0) ? 16'h0 : (we && wa == a2) ? wd : mdl_data[a2]);
      exp_q.push_back((a1 == 0 || (we && wa == a1)) ? 16'h0 : W'(mdl_pend[a1]));
      exp_q.push_back((a2 == 0 || (we && wa == a2)) ? 16'h0 : W'(mdl_pend[a2]));
      exp_q.push_back(W'(|mdl_pend));
      sample();
      exp = exp_q.pop_front(); n_cmp++;
      if (rs1_data !== exp) begin n_err++; $display("FAIL rnd_rs1 n%0d r%0d: got %h want %h", n, a1, rs1_data, exp); end
      exp = exp_q.pop_front(); n_cmp++;
      if (rs2_data !== exp) begin n_err++; $display("FAIL rnd_rs2 n%0d r%0d: got %h want %h", n, a2, rs2_data, exp); end
      exp = exp_q.pop_front(); n_cmp++;
      if (W'(rs1_pending) !== exp) begin n_err++; $display("FAIL rnd_p1 n%0d r%0d: got %h want %h", n, a1, rs1_pending, exp); end
      exp = exp_q.pop_front(); n_cmp++;
      if (W'(rs2_pending) !== exp) begin n_err++; $display("FAIL rnd_p2 n%0d r%0d: got %h want %h", n, a2, rs2_pending, exp); end
      exp = exp_q.pop_front(); n_cmp++;
      if (W'(any_pending) !== exp) begin n_err++; $display("FAIL rnd_any n%0d: got %h want %h", n, any_pending, exp); end
      // model state update for the coming edge
      if (we && wa != 0) begin
        mdl_data[wa] = wd;
        mdl_pend[wa] = 1'b0;
      end
      if (le && la != 0) mdl_pend[la] = 1'b1;
    end
    tick();
    drive(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 4'd0, 4'd0);
  endtask

  // ---------------------------------------------------------------- sequence
  initial begin
    drive(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 4'd0, 4'd0);
    test_reset();
    test_write_read();
    test_bypass();
    test_zero_reg();
    test_scoreboard();
    test_reset_clear();
    test_reset_during_lock();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/register_file.md
# register_file

Parametrised multi-port register file with a per-register pending-write scoreboard; the next generation of the single 16-bit `register` block. It holds the processor's architectural registers and provides two combinational read ports and one clocked write port. Optional same-cycle write-to-read bypass and a hardwired zero register are selected by parameter. The scoreboard lets the pipeline mark a register as "result outstanding" and detect hazards on read.

## Interface
- `WIDTH`, 16, data width of each register in bits.
- `ADDR_W`, 4, address width; depth is 2^ADDR_W registers.
- `ZERO_REG`, 1, if 1, register 0 always reads 0 and ignores writes and locks.
- `BYPASS`, 1, if 1, a same-cycle write is forwarded to the read ports.

Ports:
- `CLK` in 1: clock; all state updates occur on the rising edge.
- `reset` in 1: asynchronous, active-low reset (asserted at 0).
- `wr_en` in 1: write strobe.
- `wr_addr` in ADDR_W: write address.
- `wr_data` in WIDTH: write data.
- `lock_en` in 1: set the pending bit of `lock_addr`.
- `lock_addr` in ADDR_W: register to mark pending.
- `rs1_addr`, `rs2_addr` in ADDR_W: read addresses.
- `rs1_data`, `rs2_data` out WIDTH: read data, combinational.
- `rs1_pending`, `rs2_pending` out 1: the addressed register has an outstanding write.
- `any_pending` out 1: OR of all pending bits.

## Operation
- Storage: 2^ADDR_W × WIDTH data registers plus 2^ADDR_W pending bits.
- Write: on a rising `CLK` edge with `reset`=1 and `wr_en`=1, `reg[wr_addr]` ← `wr_data` and `pend[wr_addr]` ← 0.
- Lock: on a rising `CLK` edge with `reset`=1 and `lock_en`=1, `pend[lock_addr]` ← 1.
- Simultaneous write and lock to the same address: data is written and the pending bit ends at 1, because the lock names a new producer.
- Write and lock to different addresses: both take effect.
- Read data:
  - `rsN_data` = `reg[rsN_addr]`.
  - If BYPASS=1, `wr_en`=1 and `wr_addr`=`rsN_addr`, `rsN_data` = `wr_data` instead.
- Read pending:
  - `rsN_pending` = `pend[rsN_addr]`.
  - If BYPASS=1, `wr_en`=1 and `wr_addr`=`rsN_addr`, `rsN_pending` = 0. This holds even if a same-cycle lock targets that address, because the lock affects only later cycles.
- ZERO_REG=1:
  - Address 0 always gives `rsN_data`=0 and `rsN_pending`=0.
  - Writes and locks to address 0 are dropped.
  - No bypass applies to address 0.
  - `pend[0]` is never set.
- Both read ports are independent and may address the same register.
- `any_pending` is the OR of the stored pending bits only. It is not affected by bypass.
- No width conversion: `wr_data` is stored verbatim, and addresses cover the full depth, so there are no out-of-range cases.

## Timing
- Reset:
  - `reset` falling to 0 immediately clears all data registers to 0 and all pending bits to 0, with no clock needed.
  - While `reset`=0, writes and locks are ignored and outputs show the cleared state: all `rsN_data`=0, all pending outputs 0, `any_pending`=0.
  - BYPASS forwarding is also suppressed while `reset`=0.
- Reset deassertion: the first rising edge with `reset`=1 performs normal writes and locks.
- Reset mid-operation: a write or lock in the same cycle as reset assertion is lost; the reset state wins.
- Write latency:
  - BYPASS=0: new data is visible on reads 1 cycle after the write edge (immediately after the edge).
  - BYPASS=1: new data is visible combinationally in the write cycle itself.
- Lock latency: `rsN_pending` rises immediately after the lock edge.
- Read path: purely combinational from `rsN_addr`, `wr_*` and stored state; no registered outputs.

## Test plan
- Reset: drive writes of 16'hFFFF to every register, then pull `reset` to 0 mid-cycle. Required: all reads 16'h0000 and `any_pending`=0 before the next `CLK` edge.
- Write/read: write 16'h8888 to r5. Required: `rs1_data`(r5)=16'h8888 after the edge; `rs2_data`(r6)=16'h0000. With BYPASS=0, r5 reads 16'h0000 during the write cycle.
- Bypass (BYPASS=1): write 16'h1234 to r3 with `rs1_addr`=`rs2_addr`=3. Required: both read 16'h1234 in the same cycle, before the edge.
- Zero register: write 16'hBEEF and lock r0. Required: `rs1_data`=0, `rs1_pending`=0 and `any_pending`=0 afterwards.
- Scoreboard:
  - Lock r7. Required: `rs1_pending`=1 and `any_pending`=1 after the edge.
  - Write 16'h00A5 to r7 with lock and write together. Required: data 16'h00A5 and pending still 1.
  - Write r7 again without a lock. Required: pending 0 and `any_pending`=0.
- Reset during lock: lock r2 and assert `reset` in the same cycle. Required: `rs1_pending`(r2)=0 after `reset` is released.
